// File: rtl/lcd_instruction_arbiter_if.sv
// Bundle of the two requester ports and the LCD_controller instruction port.
// The arbiter connects through the slave modport; the surrounding system
// (requesters plus LCD_controller) uses the master modport.
interface lcd_instruction_arbiter_if;
    // Requester A (typically the character writer)
    logic       Req_A_valid;
    logic [8:0] Req_A_instruction;
    logic       Req_A_lock;
    logic       Req_A_ack;

    // Requester B (typically the line/cursor manager)
    logic       Req_B_valid;
    logic [8:0] Req_B_instruction;
    logic       Req_B_lock;
    logic       Req_B_ack;

    // LCD_controller side
    logic       LCD_start;
    logic [8:0] LCD_instruction;
    logic       LCD_done;

    // Status
    logic       Init_done;
    logic [1:0] Grant;

    modport slave (
        input  Req_A_valid, Req_A_instruction, Req_A_lock,
        output Req_A_ack,
        input  Req_B_valid, Req_B_instruction, Req_B_lock,
        output Req_B_ack,
        output LCD_start, LCD_instruction,
        input  LCD_done,
        output Init_done, Grant
    );

    modport master (
        output Req_A_valid, Req_A_instruction, Req_A_lock,
        input  Req_A_ack,
        output Req_B_valid, Req_B_instruction, Req_B_lock,
        input  Req_B_ack,
        input  LCD_start, LCD_instruction,
        output LCD_done,
        input  Init_done, Grant
    );
endinterface

// File: rtl/lcd_instruction_arbiter.sv
// LCD instruction arbiter: runs the fixed 5-entry LCD power-up sequence, then
// shares the single LCD_controller instruction port between requesters A and B
// using round-robin arbitration, with an optional per-requester lock that
// keeps the grant across a burst of instructions.
module lcd_instruction_arbiter (
    input  logic                       Clock_50,
    input  logic                       Resetn,
    lcd_instruction_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_e;

    // One-hot owner encodings, shared by Grant and lock_owner.
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_A    = 2'b01;
    localparam logic [1:0] OWN_B    = 2'b10;

    localparam logic [2:0] INIT_LAST = 3'd4;

    // Power-up sequence: function set, display on, clear, entry mode, home.
    function automatic logic [8:0] init_entry(input logic [2:0] idx);
        logic [8:0] entry;
        case (idx)
            3'd0:    entry = 9'h038;
            3'd1:    entry = 9'h00C;
            3'd2:    entry = 9'h001;
            3'd3:    entry = 9'h006;
            default: entry = 9'h080;
        endcase
        return entry;
    endfunction

    state_e     state_q,       state_d;
    logic [2:0] init_idx_q,    init_idx_d;
    logic       init_done_q,   init_done_d;
    logic       start_q,       start_d;
    logic [8:0] instr_q,       instr_d;
    logic [1:0] grant_q,       grant_d;
    logic [1:0] lock_owner_q,  lock_owner_d;
    logic       last_b_q,      last_b_d;     // 1: B was served last, so A is preferred
    logic       ack_a_q,       ack_a_d;
    logic       ack_b_q,       ack_b_d;

    // Eligibility and round-robin winner, evaluated only in S_IDLE.
    logic       elig_a;
    logic       elig_b;
    logic       win_a;
    logic       win_b;
    logic       owner_lock;
    logic       lock_release;

    // Work out who may be granted this cycle and whether an idle lock lapses.
    always_comb begin
        elig_a = bus.Req_A_valid && (lock_owner_q != OWN_B);
        elig_b = bus.Req_B_valid && (lock_owner_q != OWN_A);
        win_a  = 1'b0;
        win_b  = 1'b0;
        if (elig_a && elig_b) begin
            win_a = last_b_q;
            win_b = !last_b_q;
        end else begin
            win_a = elig_a;
            win_b = elig_b;
        end
        // A lock lapses when its owner neither wants it nor has work queued.
        lock_release = ((lock_owner_q == OWN_A) && !bus.Req_A_lock && !bus.Req_A_valid) ||
                       ((lock_owner_q == OWN_B) && !bus.Req_B_lock && !bus.Req_B_valid);
        // Lock request of whoever currently holds the grant.
        owner_lock   = grant_q[0] ? bus.Req_A_lock : bus.Req_B_lock;
    end

    // Next-state and next-output computation for the init/arbitration FSM.
    always_comb begin
        // NOTE: every *_d starts from its current value so no path through
        // the case statement leaves a signal unassigned and infers a latch.
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        init_done_d  = init_done_q;
        start_d      = start_q;
        instr_d      = instr_q;
        grant_d      = grant_q;
        lock_owner_d = lock_owner_q;
        last_b_d     = last_b_q;
        ack_a_d      = ack_a_q;
        ack_b_d      = ack_b_q;

        case (state_q)
            S_INIT_ISSUE: begin
                instr_d = init_entry(init_idx_q);
                start_d = 1'b1;
                state_d = S_INIT_WAIT;
            end

            S_INIT_WAIT: begin
                if (start_q) begin
                    // Done coinciding with our own start pulse is stale.
                    start_d = 1'b0;
                end else if (bus.LCD_done) begin
                    if (init_idx_q < INIT_LAST) begin
                        init_idx_d = init_idx_q + 3'd1;
                        state_d    = S_INIT_ISSUE;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
            end

            S_IDLE: begin
                if (lock_release) begin
                    // Normal arbitration resumes next cycle.
                    lock_owner_d = OWN_NONE;
                    grant_d      = OWN_NONE;
                end else if (win_a) begin
                    grant_d = OWN_A;
                    instr_d = bus.Req_A_instruction;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end else if (win_b) begin
                    grant_d = OWN_B;
                    instr_d = bus.Req_B_instruction;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                start_d = 1'b0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (bus.LCD_done) begin
                    ack_a_d      = grant_q[0];
                    ack_b_d      = grant_q[1];
                    last_b_d     = grant_q[1];
                    lock_owner_d = owner_lock ? grant_q : OWN_NONE;
                    state_d      = S_ACK;
                end
            end

            S_ACK: begin
                ack_a_d = 1'b0;
                ack_b_d = 1'b0;
                if (lock_owner_q == OWN_NONE) begin
                    grant_d = OWN_NONE;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_INIT_ISSUE;
            end
        endcase
    end

    // State and output registers; reset restarts the init sequence.
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        // NOTE: every flop here has an explicit async reset value, so reset
        // mid-transaction drops any pending ack and returns outputs at once.
        if (!Resetn) begin
            state_q      <= S_INIT_ISSUE;
            init_idx_q   <= 3'd0;
            init_done_q  <= 1'b0;
            start_q      <= 1'b0;
            instr_q      <= 9'h000;
            grant_q      <= OWN_NONE;
            lock_owner_q <= OWN_NONE;
            last_b_q     <= 1'b1;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            init_done_q  <= init_done_d;
            start_q      <= start_d;
            instr_q      <= instr_d;
            grant_q      <= grant_d;
            lock_owner_q <= lock_owner_d;
            last_b_q     <= last_b_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
        end
    end

    assign bus.LCD_start       = start_q;
    assign bus.LCD_instruction = instr_q;
    assign bus.Init_done       = init_done_q;
    assign bus.Grant           = grant_q;
    assign bus.Req_A_ack       = ack_a_q;
    assign bus.Req_B_ack       = ack_b_q;

endmodule

// File: tb/tb_lcd_instruction_arbiter.sv
// Directed testbench for lcd_instruction_arbiter: a small LCD_controller
// model answers each start pulse, monitors log every start and ack, and the
// main sequence walks init, single requests, round-robin, lock bursts,
// reset mid-transaction and a permanently-high done.
module tb_lcd_instruction_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #10 clk = ~clk;

    lcd_instruction_arbiter_if bus ();

    lcd_instruction_arbiter dut (
        .Clock_50 (clk),
        .Resetn   (rst_n),
        .bus      (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // LCD_controller model: done pulses lcd_delay cycles after a start,
    // or sits high permanently when lcd_hold is set.
    int lcd_delay = 3;
    bit lcd_hold  = 1'b0;
    int lcd_cnt   = 0;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            lcd_cnt      = 0;
            bus.LCD_done = lcd_hold;
        end else if (lcd_hold) begin
            bus.LCD_done = 1'b1;
        end else begin
            bus.LCD_done = 1'b0;
            if (bus.LCD_start === 1'b1) begin
                lcd_cnt = lcd_delay;
            end else if (lcd_cnt > 0) begin
                lcd_cnt--;
                if (lcd_cnt == 0) bus.LCD_done = 1'b1;
            end
        end
    end

    // Monitors: log issued instructions and acks, flag anomalies.
    logic [8:0] start_log[$];
    int         ack_log[$];     // 0 = A, 1 = B
    int         ack_early    = 0;
    int         start_double = 0;
    bit         prev_start   = 1'b0;

    always @(negedge clk) begin
        if (bus.LCD_start === 1'b1) begin
            start_log.push_back(bus.LCD_instruction);
            if (prev_start) start_double++;
        end
        prev_start = (bus.LCD_start === 1'b1);
        if (bus.Req_A_ack === 1'b1) begin
            ack_log.push_back(0);
            if (bus.Init_done !== 1'b1) ack_early++;
        end
        if (bus.Req_B_ack === 1'b1) begin
            ack_log.push_back(1);
            if (bus.Init_done !== 1'b1) ack_early++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init();
        int n = 0;
        while (bus.Init_done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check("init_done_reached", 32'(bus.Init_done), 32'd1);
    endtask

    task automatic wait_ack(input int who);
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            step();
            seen = (who == 1) ? (bus.Req_B_ack === 1'b1) : (bus.Req_A_ack === 1'b1);
        end
        check("ack_wait", 32'(seen), 32'd1);
    endtask

    logic [8:0] init_seq [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    logic [8:0] rr_a     [3] = '{9'h101, 9'h102, 9'h103};
    logic [8:0] rr_b     [3] = '{9'h1A1, 9'h1A2, 9'h1A3};
    logic [8:0] rr_exp   [6] = '{9'h101, 9'h1A1, 9'h102, 9'h1A2, 9'h103, 9'h1A3};
    logic [8:0] lk_b     [4] = '{9'h0C0, 9'h141, 9'h142, 9'h143};
    logic       lk_l     [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [8:0] lk_exp   [5] = '{9'h0C0, 9'h141, 9'h142, 9'h143, 9'h1F0};
    int         lk_ack   [5] = '{1, 1, 1, 1, 0};

    initial begin
        int base;
        int ack_base;
        int a_idx;
        int b_idx;
        int first_ack;

        rst_n                 = 1'b0;
        bus.Req_A_valid       = 1'b0;
        bus.Req_A_instruction = 9'h000;
        bus.Req_A_lock        = 1'b0;
        bus.Req_B_valid       = 1'b0;
        bus.Req_B_instruction = 9'h000;
        bus.Req_B_lock        = 1'b0;
        repeat (3) step();

        // Reset values
        check("rst_start",     32'(bus.LCD_start),       32'd0);
        check("rst_instr",     32'(bus.LCD_instruction), 32'h000);
        check("rst_ack_a",     32'(bus.Req_A_ack),       32'd0);
        check("rst_ack_b",     32'(bus.Req_B_ack),       32'd0);
        check("rst_grant",     32'(bus.Grant),           32'd0);
        check("rst_init_done", 32'(bus.Init_done),       32'd0);

        // Init sequence, with A requesting while it runs
        rst_n = 1'b1;
        step();
        step();
        bus.Req_A_instruction = 9'h155;
        bus.Req_A_valid       = 1'b1;
        wait_init();
        check("init_count", start_log.size(), 5);
        for (int i = 0; i < 5; i++) check("init_seq", 32'(start_log[i]), 32'(init_seq[i]));
        wait_ack(0);
        bus.Req_A_valid = 1'b0;
        check("init_req_instr", 32'(start_log[5]), 32'h155);
        check("init_no_early_ack", ack_early, 0);
        step();
        step();

        // Single A request, cycle-accurate
        bus.Req_A_instruction = 9'h141;
        bus.Req_A_valid       = 1'b1;
        step();
        check("a_start_hi",  32'(bus.LCD_start),       32'd1);
        check("a_instr",     32'(bus.LCD_instruction), 32'h141);
        check("a_grant",     32'(bus.Grant),           32'h1);
        bus.Req_A_instruction = 9'h1FF;
        step();
        check("a_start_lo",  32'(bus.LCD_start),       32'd0);
        check("a_instr_hold",32'(bus.LCD_instruction), 32'h141);
        step();
        step();
        check("a_ack_not_yet", 32'(bus.Req_A_ack), 32'd0);
        step();
        check("a_ack",       32'(bus.Req_A_ack), 32'd1);
        check("a_ack_b",     32'(bus.Req_B_ack), 32'd0);
        check("a_ack_grant", 32'(bus.Grant),     32'h1);
        bus.Req_A_valid = 1'b0;
        step();
        check("a_ack_end",   32'(bus.Req_A_ack), 32'd0);
        check("a_grant_clr", 32'(bus.Grant),     32'h0);
        step();

        // Single B request so that A is preferred next
        bus.Req_B_instruction = 9'h1C5;
        bus.Req_B_valid       = 1'b1;
        wait_ack(1);
        bus.Req_B_valid = 1'b0;
        check("b_instr", 32'(start_log[start_log.size() - 1]), 32'h1C5);
        step();
        step();

        // Round-robin: both valid together, three each
        base     = start_log.size();
        ack_base = ack_log.size();
        a_idx    = 0;
        b_idx    = 0;
        bus.Req_A_instruction = rr_a[0];
        bus.Req_B_instruction = rr_b[0];
        bus.Req_A_valid       = 1'b1;
        bus.Req_B_valid       = 1'b1;
        for (int n = 0; n < 300 && (a_idx < 3 || b_idx < 3); n++) begin
            step();
            if (bus.Req_A_ack === 1'b1) begin
                a_idx++;
                if (a_idx < 3) bus.Req_A_instruction = rr_a[a_idx];
                else           bus.Req_A_valid = 1'b0;
            end
            if (bus.Req_B_ack === 1'b1) begin
                b_idx++;
                if (b_idx < 3) bus.Req_B_instruction = rr_b[b_idx];
                else           bus.Req_B_valid = 1'b0;
            end
        end
        check("rr_complete", 32'(a_idx == 3 && b_idx == 3), 32'd1);
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            check("rr_order", 32'(start_log[base + i]), 32'(rr_exp[i]));
            check("rr_ack",   ack_log[ack_base + i], i % 2);
        end

        // Lock burst by B while A is continuously valid
        base     = start_log.size();
        ack_base = ack_log.size();
        b_idx    = 0;
        a_idx    = 0;
        bus.Req_B_instruction = lk_b[0];
        bus.Req_B_lock        = lk_l[0];
        bus.Req_B_valid       = 1'b1;
        step();
        bus.Req_A_instruction = 9'h1F0;
        bus.Req_A_valid       = 1'b1;
        for (int n = 0; n < 300 && (a_idx < 1 || b_idx < 4); n++) begin
            step();
            if (bus.Req_B_ack === 1'b1) begin
                b_idx++;
                if (b_idx < 4) begin
                    bus.Req_B_instruction = lk_b[b_idx];
                    bus.Req_B_lock        = lk_l[b_idx];
                end else begin
                    bus.Req_B_valid = 1'b0;
                end
            end
            if (bus.Req_A_ack === 1'b1) begin
                a_idx++;
                bus.Req_A_valid = 1'b0;
            end
        end
        check("lock_complete", 32'(a_idx == 1 && b_idx == 4), 32'd1);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("lock_order", 32'(start_log[base + i]), 32'(lk_exp[i]));
            check("lock_ack",   ack_log[ack_base + i], lk_ack[i]);
        end

        // Reset during S_WAIT of an A request
        bus.Req_A_instruction = 9'h1AA;
        bus.Req_A_valid       = 1'b1;
        step();
        step();
        step();
        ack_base = ack_log.size();
        rst_n = 1'b0;
        #1;
        check("mid_rst_start", 32'(bus.LCD_start),       32'd0);
        check("mid_rst_grant", 32'(bus.Grant),           32'h0);
        check("mid_rst_ack",   32'(bus.Req_A_ack),       32'd0);
        check("mid_rst_init",  32'(bus.Init_done),       32'd0);
        check("mid_rst_instr", 32'(bus.LCD_instruction), 32'h000);
        step();
        step();
        base  = start_log.size();
        rst_n = 1'b1;
        wait_init();
        check("replay_count", start_log.size() - base, 5);
        for (int i = 0; i < 5; i++) check("replay_seq", 32'(start_log[base + i]), 32'(init_seq[i]));
        check("mid_rst_ack_lost", ack_log.size() - ack_base, 0);
        wait_ack(0);
        bus.Req_A_valid = 1'b0;
        check("replay_req_instr", 32'(start_log[base + 5]), 32'h1AA);
        step();
        step();

        // LCD_done held permanently high
        lcd_hold = 1'b1;
        step();
        step();
        base      = start_log.size();
        ack_base  = ack_log.size();
        a_idx     = 0;
        b_idx     = 0;
        first_ack = 0;
        bus.Req_A_instruction = 9'h1B1;
        bus.Req_B_instruction = 9'h1B2;
        bus.Req_A_valid       = 1'b1;
        bus.Req_B_valid       = 1'b1;
        for (int n = 1; n < 100 && (a_idx < 1 || b_idx < 1); n++) begin
            step();
            if (bus.Req_A_ack === 1'b1) begin
                a_idx++;
                bus.Req_A_valid = 1'b0;
            end
            if (bus.Req_B_ack === 1'b1) begin
                b_idx++;
                bus.Req_B_valid = 1'b0;
                if (first_ack == 0) first_ack = n;
            end
        end
        repeat (10) step();
        check("hold_first_ack_cycle", first_ack, 3);
        check("hold_starts", start_log.size() - base, 2);
        check("hold_acks",   ack_log.size() - ack_base, 2);
        check("hold_order0", 32'(start_log[base]),     32'h1B2);
        check("hold_order1", 32'(start_log[base + 1]), 32'h1B1);
        check("hold_ack0",   ack_log[ack_base],     1);
        check("hold_ack1",   ack_log[ack_base + 1], 0);
        lcd_hold = 1'b0;

        check("start_single_cycle", start_double, 0);
        check("no_ack_before_init", ack_early, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
